// File: rtl/rave_ooo_pkg.sv
// Shared out-of-order core definitions.
//   PRW / ROBW : tag widths derived from the physical register file and ROB sizes.
//   bcast_t    : one result broadcast (dest phys reg, value, ROB entry). The same
//                struct is consumed by the reservation-station update inputs.
package rave_ooo_pkg;

  localparam int XLEN          = 32;
  localparam int PHYS_REG_SIZE = 256;
  localparam int ROB_SIZE      = 265;
  localparam int PRW           = $clog2(PHYS_REG_SIZE);
  localparam int ROBW          = $clog2(ROB_SIZE);

  typedef struct packed {
    logic [PRW-1:0]  preg;
    logic [XLEN-1:0] val;
    logic [ROBW-1:0] rob;
  } bcast_t;

endpackage

// File: rtl/bcast_src_fifo.sv
// Per-source completion buffer: small synchronous FIFO of bcast_t.
//   clk, rst    : clock, synchronous active-high reset
//   flush       : synchronous clear of all entries (push ignored that cycle)
//   push/push_data : write one entry (caller guarantees not full)
//   pop         : drop the head entry (caller guarantees not empty)
//   head        : current head entry, valid while empty=0
//   empty/count : occupancy, count never exceeds DEPTH
module bcast_src_fifo
  import rave_ooo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  bcast_t                 push_data,
  input  logic                   pop,
  output bcast_t                 head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bcast_t        mem_q [DEPTH];
  bcast_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Cleared so the head is never X, keeping the broadcast outputs X-free.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/result_bcast_arb.sv
// Result/wakeup broadcast producer.
// Collects completions from NUM_SRC functional units (valid/ready), buffers each
// source in its own FIFO and round-robin arbitrates one registered broadcast per
// cycle onto update_valid/update_reg/update_val/update_rob.
//   clk, rst      : clock, synchronous active-high reset (overrides flush)
//   src_valid     : per-source completion valid
//   src_ready     : per-source FIFO has room (registered occupancy only)
//   src_reg/val/rob : packed per-source result fields, source i at [i*W +: W]
//   flush         : discard every buffered result, restart arbitration at source 0
//   update_*      : registered broadcast; data holds when no broadcast issues
module result_bcast_arb
  import rave_ooo_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [NUM_SRC*PRW-1:0]  src_reg,
  input  logic [NUM_SRC*XLEN-1:0] src_val,
  input  logic [NUM_SRC*ROBW-1:0] src_rob,
  input  logic                    flush,
  output logic                    update_valid,
  output logic [PRW-1:0]          update_reg,
  output logic [XLEN-1:0]         update_val,
  output logic [ROBW-1:0]         update_rob
);

  localparam int RRW = $clog2(NUM_SRC);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  bcast_t             head_w  [NUM_SRC];
  logic [CW-1:0]      count_w [NUM_SRC];
  logic [NUM_SRC-1:0] empty_w;
  logic [NUM_SRC-1:0] push_w;
  logic [NUM_SRC-1:0] pop_w;

  logic               grant_valid;
  logic [RRW-1:0]     winner;
  logic [RRW-1:0]     cand;

  logic [RRW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               update_valid_q, update_valid_d;
  bcast_t             upd_q, upd_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      bcast_t in_w;
      assign in_w.preg = src_reg[gi*PRW +: PRW];
      assign in_w.val  = src_val[gi*XLEN +: XLEN];
      assign in_w.rob  = src_rob[gi*ROBW +: ROBW];

      // Ready comes from the registered count only: a pop this cycle does not
      // free a slot until the next cycle.
      assign src_ready[gi] = (count_w[gi] < CW'(FIFO_DEPTH));

      // Physical register 0 carries no wakeup: the handshake completes but the
      // result is never stored. Transfers in a flush cycle are discarded.
      assign push_w[gi] = src_valid[gi] & src_ready[gi] & ~flush & (in_w.preg != '0);
      assign pop_w[gi]  = grant_valid & (winner == RRW'(gi));

      bcast_src_fifo #(
        .DEPTH(FIFO_DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push_w[gi]),
        .push_data(in_w),
        .pop      (pop_w[gi]),
        .head     (head_w[gi]),
        .empty    (empty_w[gi]),
        .count    (count_w[gi])
      );
    end
  endgenerate

  // Round-robin search: first non-empty source at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    winner      = '0;
    cand        = rr_ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_valid && !empty_w[cand]) begin
        grant_valid = 1'b1;
        winner      = cand;
      end
      cand = (cand == RRW'(NUM_SRC - 1)) ? '0 : cand + RRW'(1);
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    update_valid_d = 1'b0;
    upd_d          = upd_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (grant_valid) begin
      update_valid_d = 1'b1;
      upd_d          = head_w[winner];
      rr_ptr_d       = (winner == RRW'(NUM_SRC - 1)) ? '0 : winner + RRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      update_valid_q <= 1'b0;
      upd_q          <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      update_valid_q <= update_valid_d;
      upd_q          <= upd_d;
    end
  end

  assign update_valid = update_valid_q;
  assign update_reg   = upd_q.preg;
  assign update_val   = upd_q.val;
  assign update_rob   = upd_q.rob;

endmodule

// File: tb/tb_result_bcast_arb.sv
module tb_result_bcast_arb;
  import rave_ooo_pkg::*;

  localparam int NS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [NS-1:0]       src_valid;
  logic [NS-1:0]       src_ready;
  logic [NS*PRW-1:0]   src_reg;
  logic [NS*XLEN-1:0]  src_val;
  logic [NS*ROBW-1:0]  src_rob;
  logic                update_valid;
  logic [PRW-1:0]      update_reg;
  logic [XLEN-1:0]     update_val;
  logic [ROBW-1:0]     update_rob;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_bcast_arb #(.NUM_SRC(NS), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_reg     (src_reg),
    .src_val     (src_val),
    .src_rob     (src_rob),
    .flush       (flush),
    .update_valid(update_valid),
    .update_reg  (update_reg),
    .update_val  (update_val),
    .update_rob  (update_rob)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input int r, input int v, input int rb);
    src_reg[i*PRW +: PRW]    = PRW'(r);
    src_val[i*XLEN +: XLEN]  = XLEN'(v);
    src_rob[i*ROBW +: ROBW]  = ROBW'(rb);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = 4'hF;
    for (int i = 0; i < NS; i++) set_src(i, i + 1, 100 + i, i + 1);
    step();
    rst       = 1'b0;
    src_valid = 4'h0;
    checks++;
    if (update_valid !== 1'b0 || update_reg !== '0 || update_val !== '0 || update_rob !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b reg=%0d val=%0d rob=%0d, want 0 0 0 0",
               update_valid, update_reg, update_val, update_rob);
    end
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1111", src_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (update_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_bcast: cycle %0d got valid=%b reg=%0d want valid=0", c, update_valid, update_reg);
      end
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    set_src(0, 1, 26, 20);
    src_valid = 4'b0001;
    step();
    src_valid = 4'b0000;
    checks++;
    if (update_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got valid=%b one cycle after accept, want 0", update_valid);
    end
    step();
    checks++;
    if (update_valid !== 1'b1 || update_reg !== 8'd1 || update_val !== 32'd26 || update_rob !== 9'd20) begin
      errors++;
      $display("FAIL single_bcast: got valid=%b reg=%0d val=%0d rob=%0d, want 1 1 26 20",
               update_valid, update_reg, update_val, update_rob);
    end
    $display("single: bcast reg=%0d val=%0d rob=%0d", update_reg, update_val, update_rob);
    step();
    checks++;
    if (update_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_once: got valid=%b on following cycle, want 0", update_valid);
    end
  endtask

  task automatic test_fairness();
    int exp_r [4] = '{6, 7, 4, 5};
    // rr_ptr is 1 here; one broadcast from source 1 moves it to 2.
    set_src(1, 30, 300, 30);
    src_valid = 4'b0010;
    step();
    src_valid = 4'b0000;
    step();
    checks++;
    if (update_valid !== 1'b1 || update_reg !== 8'd30) begin
      errors++;
      $display("FAIL fair_setup: got valid=%b reg=%0d, want 1 30", update_valid, update_reg);
    end
    for (int i = 0; i < NS; i++) set_src(i, 4 + i, 40 + i, 1 + i);
    src_valid = 4'hF;
    step();
    src_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (update_valid !== 1'b1 || update_reg !== PRW'(exp_r[k]) ||
          update_val !== XLEN'(exp_r[k] + 36) || update_rob !== ROBW'(exp_r[k] - 3)) begin
        errors++;
        $display("FAIL fair_order[%0d]: got valid=%b reg=%0d val=%0d rob=%0d, want 1 %0d %0d %0d",
                 k, update_valid, update_reg, update_val, update_rob, exp_r[k], exp_r[k] + 36, exp_r[k] - 3);
      end
      $display("fairness: bcast %0d reg=%0d", k, update_reg);
    end
    step();
    checks++;
    if (update_valid !== 1'b0) begin
      errors++;
      $display("FAIL fair_idle: got valid=%b, want 0", update_valid);
    end
  endtask

  // rr_ptr starts at 2. Sources 0/2/3 each push two results while source 1
  // streams 10,11,12,13; source 1 stalls whenever its FIFO holds two entries.
  task automatic test_back_to_back_backpressure();
    logic [3:0] vld   [11] = '{4'hF, 4'hF, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    int         r1    [11] = '{10, 11, 12, 12, 12, 12, 13, 13, 13, 13, 0};
    logic [3:0] rdy   [11] = '{4'hF, 4'hF, 4'b0100, 4'b1100, 4'b1101, 4'hF,
                               4'b1101, 4'b1101, 4'b1101, 4'hF, 4'hF};
    int         exp_r [11] = '{0, 40, 50, 30, 10, 41, 51, 31, 11, 12, 13};
    for (int k = 0; k < 11; k++) begin
      src_valid = vld[k];
      set_src(1, r1[k], r1[k] + 1000, r1[k]);
      set_src(0, 30 + k, 30 + k + 1000, 30 + k);
      set_src(2, 40 + k, 40 + k + 1000, 40 + k);
      set_src(3, 50 + k, 50 + k + 1000, 50 + k);
      checks++;
      if (src_ready !== rdy[k]) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b want %b", k, src_ready, rdy[k]);
      end
      step();
      checks++;
      if (exp_r[k] == 0) begin
        if (update_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_bcast[%0d]: got valid=%b reg=%0d, want valid=0", k, update_valid, update_reg);
        end
      end else if (update_valid !== 1'b1 || update_reg !== PRW'(exp_r[k]) ||
                   update_val !== XLEN'(exp_r[k] + 1000) || update_rob !== ROBW'(exp_r[k])) begin
        errors++;
        $display("FAIL bp_bcast[%0d]: got valid=%b reg=%0d val=%0d rob=%0d, want 1 %0d %0d %0d",
                 k, update_valid, update_reg, update_val, update_rob, exp_r[k], exp_r[k] + 1000, exp_r[k]);
      end
      $display("backpressure: cycle %0d ready=%b bcast valid=%b reg=%0d", k, rdy[k], update_valid, update_reg);
    end
    step();
    checks++;
    if (update_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b reg=%0d, want valid=0", update_valid, update_reg);
    end
  endtask

  task automatic test_p0_drop();
    set_src(2, 0, 99, 5);
    src_valid = 4'b0100;
    step();
    set_src(2, 3, 7, 6);
    checks++;
    if (update_valid !== 1'b0) begin
      errors++;
      $display("FAIL p0_none1: got valid=%b reg=%0d, want 0", update_valid, update_reg);
    end
    step();
    src_valid = 4'b0000;
    checks++;
    if (update_valid !== 1'b0) begin
      errors++;
      $display("FAIL p0_dropped: got valid=%b reg=%0d val=%0d, want valid=0", update_valid, update_reg, update_val);
    end
    step();
    checks++;
    if (update_valid !== 1'b1 || update_reg !== 8'd3 || update_val !== 32'd7 || update_rob !== 9'd6) begin
      errors++;
      $display("FAIL p0_bcast: got valid=%b reg=%0d val=%0d rob=%0d, want 1 3 7 6",
               update_valid, update_reg, update_val, update_rob);
    end
    $display("p0_drop: bcast reg=%0d val=%0d", update_reg, update_val);
    step();
    checks++;
    if (update_valid !== 1'b0 || update_reg !== 8'd3 || update_val !== 32'd7) begin
      errors++;
      $display("FAIL p0_hold: got valid=%b reg=%0d val=%0d, want 0 3 7", update_valid, update_reg, update_val);
    end
  endtask

  // rr_ptr starts at 3.
  task automatic test_flush();
    set_src(0, 60, 600, 60);
    set_src(3, 70, 700, 70);
    src_valid = 4'b1001;
    step();
    set_src(0, 61, 601, 61);
    set_src(3, 71, 701, 71);
    step();
    checks++;
    if (update_valid !== 1'b1 || update_reg !== 8'd70) begin
      errors++;
      $display("FAIL flush_pre: got valid=%b reg=%0d, want 1 70", update_valid, update_reg);
    end
    set_src(0, 62, 602, 62);
    set_src(3, 73, 703, 73);
    flush = 1'b1;
    step();
    flush     = 1'b0;
    src_valid = 4'b0000;
    checks++;
    if (update_valid !== 1'b0 || update_reg !== 8'd70) begin
      errors++;
      $display("FAIL flush_idle: got valid=%b reg=%0d, want 0 70", update_valid, update_reg);
    end
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL flush_ready: got %b want 1111", src_ready);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (update_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty[%0d]: got valid=%b reg=%0d, want 0", c, update_valid, update_reg);
      end
    end
    set_src(1, 80, 800, 80);
    src_valid = 4'b0010;
    step();
    src_valid = 4'b0000;
    step();
    checks++;
    if (update_valid !== 1'b1 || update_reg !== 8'd80 || update_val !== 32'd800 || update_rob !== 9'd80) begin
      errors++;
      $display("FAIL flush_resume: got valid=%b reg=%0d val=%0d rob=%0d, want 1 80 800 80",
               update_valid, update_reg, update_val, update_rob);
    end
    $display("flush: post-flush bcast reg=%0d", update_reg);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_reg   = '0;
    src_val   = '0;
    src_rob   = '0;
    #2;
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back_backpressure();
    test_p0_drop();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
